// File: rtl/dsp_mul_signed_comb.sv
// ---------------------------------------------------------------------------
// dsp_mul_signed_comb
//
// Purpose:
//   Signed A_WIDTH x B_WIDTH multiplier. The combinational product is built
//   from a radix-4 modified-Booth recoding of B, a carry-save (3:2) reduction
//   tree and one final carry-propagate adder. A registered copy of the
//   product is also provided.
//
// Ports:
//   A     - in,  A_WIDTH bits, signed multiplicand
//   B     - in,  B_WIDTH bits, signed multiplier
//   P     - out, A_WIDTH+B_WIDTH bits, signed combinational product A*B
//   clk   - in,  clock, rising edge
//   rst_n - in,  synchronous active-low reset (clears P_q only)
//   P_q   - out, A_WIDTH+B_WIDTH bits, P registered once per clock
//
// The reduction tree is laid out explicitly for the default 20x18
// configuration: 10 Booth partial products plus one correction vector.
// ---------------------------------------------------------------------------
module dsp_mul_signed_comb #(
  parameter int A_WIDTH = 20,
  parameter int B_WIDTH = 18
) (
  input  logic signed [A_WIDTH-1:0]         A,
  input  logic signed [B_WIDTH-1:0]         B,
  output logic signed [A_WIDTH+B_WIDTH-1:0] P,
  input  logic                              clk,
  input  logic                              rst_n,
  output logic signed [A_WIDTH+B_WIDTH-1:0] P_q
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  // B is sign-extended to 19 bits and then padded to an even digit count,
  // which yields 10 Booth digits for an 18-bit multiplier.
  localparam int NUM_PP  = (B_WIDTH + 2) / 2;
  localparam int NUM_OPS = NUM_PP + 1;
  localparam int B_EXT   = 2 * NUM_PP - B_WIDTH;

  typedef logic [P_WIDTH-1:0] vec_t;

  // 3:2 compressor over whole vectors; returns {carry, sum}. The carry bit
  // shifted out of the top is dropped, which is correct for modulo-2^P_WIDTH
  // two's-complement arithmetic.
  function automatic logic [2*P_WIDTH-1:0] csa(input vec_t x, input vec_t y, input vec_t z);
    vec_t s;
    vec_t c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  // Multiplier with its implicit b[-1] = 0 appended; each overlapping bit
  // triplet selects one Booth digit.
  logic [2*NUM_PP:0] b_ext;
  vec_t              a_ext;
  vec_t              a_dbl;

  assign b_ext = {{B_EXT{B[B_WIDTH-1]}}, B, 1'b0};
  assign a_ext = {{B_WIDTH{A[A_WIDTH-1]}}, A};
  assign a_dbl = a_ext << 1;

  vec_t pp [NUM_PP];
  vec_t corr;
  vec_t ops [NUM_OPS];

  logic [2:0] trip;
  vec_t       mag;
  logic       neg;

  // Booth digit selection. A negative digit is produced as the ones'
  // complement of the shifted magnitude; the missing +1 at weight 2^(2i) is
  // collected in the correction vector, which enters the tree as an extra
  // operand instead of needing any subtractor.
  always_comb begin
    corr = '0;
    trip = '0;
    mag  = '0;
    neg  = 1'b0;
    for (int i = 0; i < NUM_PP; i++) begin
      trip = b_ext[2*i +: 3];
      mag  = '0;
      neg  = 1'b0;
      case (trip)
        3'b001, 3'b010: mag = a_ext;
        3'b011:         mag = a_dbl;
        3'b100: begin
          mag = a_dbl;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = a_ext;
          neg = 1'b1;
        end
        default:        mag = '0;
      endcase
      pp[i]      = (neg ? ~mag : mag) << (2 * i);
      corr[2*i]  = neg;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PP; i++) begin
      ops[i] = pp[i];
    end
    ops[NUM_PP] = corr;
  end

  // Carry-save tree: 11 -> 8 -> 6 -> 4 -> 3 -> 2 operands.
  vec_t st1 [8];
  vec_t st2 [6];
  vec_t st3 [4];
  vec_t st4 [3];
  vec_t st5 [2];

  assign {st1[1], st1[0]} = csa(ops[0], ops[1], ops[2]);
  assign {st1[3], st1[2]} = csa(ops[3], ops[4], ops[5]);
  assign {st1[5], st1[4]} = csa(ops[6], ops[7], ops[8]);
  assign st1[6]           = ops[9];
  assign st1[7]           = ops[10];

  assign {st2[1], st2[0]} = csa(st1[0], st1[1], st1[2]);
  assign {st2[3], st2[2]} = csa(st1[3], st1[4], st1[5]);
  assign st2[4]           = st1[6];
  assign st2[5]           = st1[7];

  assign {st3[1], st3[0]} = csa(st2[0], st2[1], st2[2]);
  assign {st3[3], st3[2]} = csa(st2[3], st2[4], st2[5]);

  assign {st4[1], st4[0]} = csa(st3[0], st3[1], st3[2]);
  assign st4[2]           = st3[3];

  assign {st5[1], st5[0]} = csa(st4[0], st4[1], st4[2]);

  // Single carry-propagate adder resolves the redundant sum/carry pair.
  assign P = st5[0] + st5[1];

  // Output register: reset wins over loading; P itself is unaffected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      P_q <= '0;
    end else begin
      P_q <= P;
    end
  end

endmodule

// File: tb/tb_dsp_mul_signed_comb.sv
// ---------------------------------------------------------------------------
// tb_dsp_mul_signed_comb
//
// Purpose:
//   Self-checking bench for dsp_mul_signed_comb. Expected products come from
//   plain 64-bit integer multiplication of the operands, truncated to the
//   38-bit product width.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_dsp_mul_signed_comb;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [19:0] a;
  logic signed [17:0] b;
  logic signed [37:0] p;
  logic signed [37:0] p_q;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic signed [19:0] a;
    logic signed [17:0] b;
    logic signed [37:0] p;
  } vec_t;

  vec_t vectors [12];

  always #5 clk = ~clk;

  dsp_mul_signed_comb #(
    .A_WIDTH(20),
    .B_WIDTH(18)
  ) dut (
    .A    (a),
    .B    (b),
    .P    (p),
    .clk  (clk),
    .rst_n(rst_n),
    .P_q  (p_q)
  );

  // Reference product straight from integer arithmetic.
  function automatic logic signed [37:0] ref_product(input logic signed [19:0] x,
                                                     input logic signed [17:0] y);
    longint prod;
    prod = longint'(x) * longint'(y);
    return prod[37:0];
  endfunction

  task automatic apply_stimulus(input logic signed [19:0] new_a, input logic signed [17:0] new_b);
    a = new_a;
    b = new_b;
  endtask

  task automatic check_output(input string name, input logic signed [37:0] actual,
                              input logic signed [37:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    logic signed [19:0] ra;
    logic signed [17:0] rb;
    logic signed [37:0] exp_q;

    vectors[0]  = '{ 20'sd5,       18'sd2,       38'sd10};
    vectors[1]  = '{-20'sd1,      -18'sd1,       38'sd1};
    vectors[2]  = '{ 20'sd0,      -18'sd131072,  38'sd0};
    vectors[3]  = '{-20'sd524288, -18'sd131072,  38'sd68719476736};
    vectors[4]  = '{-20'sd524288,  18'sd131071, -38'sd68718952448};
    vectors[5]  = '{ 20'sd524287,  18'sd131071,  38'sd68718821377};
    vectors[6]  = '{ 20'sd524287, -18'sd131072, -38'sd68719345664};
    vectors[7]  = '{-20'sd524288,  18'sd0,       38'sd0};
    vectors[8]  = '{ 20'sd1,      -18'sd1,      -38'sd1};
    vectors[9]  = '{-20'sd524288, -18'sd1,       38'sd524288};
    vectors[10] = '{ 20'sd3,      -18'sd87382,  -38'sd262146};
    vectors[11] = '{-20'sd524288,  18'sd1,      -38'sd524288};

    rst_n = 1'b0;
    apply_stimulus(20'sd0, 18'sd0);
    repeat (2) @(negedge clk);
    check_output("reset_state_p_q", p_q, 38'sd0);

    // Directed table: combinational product only, no edge needed.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vectors[i].a, vectors[i].b);
      #10;
      check_output($sformatf("table_%0d", i), p, vectors[i].p);
    end

    // Random operand pairs against the reference model.
    for (int i = 0; i < 32; i++) begin
      ra = 20'($urandom);
      rb = 18'($urandom);
      apply_stimulus(ra, rb);
      #10;
      check_output($sformatf("random_%0d", i), p, ref_product(ra, rb));
    end

    // Reset holds P_q at 0 while P keeps tracking.
    @(negedge clk);
    rst_n = 1'b0;
    apply_stimulus(20'sd5, 18'sd2);
    repeat (2) @(negedge clk);
    check_output("reset_hold_p_q", p_q, 38'sd0);
    check_output("reset_hold_p", p, 38'sd10);

    rst_n = 1'b1;
    @(negedge clk);
    check_output("first_load_p_q", p_q, 38'sd10);

    // Operand change between edges: P immediate, P_q one edge later.
    apply_stimulus(-20'sd3, 18'sd2);
    #1;
    check_output("latency_p_now", p, -38'sd6);
    check_output("latency_p_q_old", p_q, 38'sd10);
    @(negedge clk);
    check_output("latency_p_q_new", p_q, -38'sd6);

    // Mid-operation reset clears only at the next edge.
    rst_n = 1'b0;
    #1;
    check_output("sync_reset_no_async", p_q, -38'sd6);
    @(negedge clk);
    check_output("sync_reset_cleared", p_q, 38'sd0);
    check_output("sync_reset_p_tracks", p, -38'sd6);
    rst_n = 1'b1;

    // Registered path with fresh random operands every cycle.
    for (int i = 0; i < 16; i++) begin
      ra = 20'($urandom);
      rb = 18'($urandom);
      apply_stimulus(ra, rb);
      exp_q = ref_product(ra, rb);
      @(negedge clk);
      check_output($sformatf("registered_%0d", i), p_q, exp_q);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
